prog_loader: RTL and testbench

Program-memory loader for the Nibbler CPU: the write side of the 4096 x 8 program store. It accepts a stream of instruction bytes over a valid/ready handshake and writes them to consecutive addresses from 0 through the program store's write port. It holds the CPU in reset while loading and reports completion and an 8-bit checksum, so programs can be loaded at run time instead of from a fixed image.

---
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader.sv | 156 +++++++++++++++
 tb/tb_prog_loader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-store write port of the Nibbler program loader.
// The loader sits on the slave side: it consumes the byte stream and drives the
// program-store write port. The byte source and the store use the master side.
interface prog_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program-memory loader for the Nibbler CPU.
// Accepts instruction bytes over valid/ready and writes them to consecutive
// program-store addresses starting at 0. Holds the CPU in reset while loading
// and reports completion plus an 8-bit running checksum of the loaded bytes.
module prog_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  prog_loader_if.slave      bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // Counter width has one spare bit so a full-depth load can count to DEPTH
  // without the address wrapping back to 0.
  localparam int               CW    = ADDR_W + 1;
  localparam logic [ADDR_W:0]  DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Requested length saturated to the program-store depth.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  // Checksum accumulation wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] sum_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  state_t            state_q,     state_d;
  logic [ADDR_W:0]   cnt_q,       cnt_d;
  logic [ADDR_W:0]   lim_q,       lim_d;
  logic [DATA_W-1:0] sum_q,       sum_d;
  logic              in_ready_q,  in_ready_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic beat;
  logic last_beat;

  // A beat needs only the registered ready, so in_valid never feeds in_ready.
  assign beat      = bus.in_valid && in_ready_q;
  assign last_beat = beat && (cnt_q == (lim_q - CW'(1)));

  // Next-state and next-output decode; all outputs are registered from here.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    sum_d       = sum_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    done_d      = done_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sum_d = '0;
          cnt_d = '0;
          if (len == '0) begin
            // Empty load completes immediately without touching the store.
            state_d    = S_DONE;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d    = S_LOAD;
            lim_d      = clamp_len(len);
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
          end
        end
      end

      S_LOAD: begin
        // start is deliberately not looked at while loading.
        if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = bus.in_data;
          sum_d       = sum_wrap(sum_q, bus.in_data);
          cnt_d       = cnt_q + CW'(1);
          if (last_beat) begin
            state_d    = S_DONE;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any write still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lim_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign cpu_hold      = busy_q;
  assign done          = done_q;
  assign checksum      = sum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a cycle model of the load rules is
// compared against the DUT every cycle, with directed literal checks on top.
module tb_prog_loader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              busy, cpu_hold, done;
  logic [DATA_W-1:0] checksum;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .len      (len),
    .bus      (bus),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: mode 0 = idle, 1 = loading, 2 = done.
  int m_mode = 0, m_cnt = 0, m_lim = 0, m_sum = 0, m_addr = 0, m_wdata = 0;
  bit m_we = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0; m_cnt <= 0; m_lim <= 0; m_sum <= 0;
      m_addr <= 0; m_wdata <= 0; m_we <= 0;
    end else begin
      m_we <= 0;
      if (m_mode != 1) begin
        if (start) begin
          m_sum <= 0;
          if (len == 0) m_mode <= 2;
          else begin
            m_mode <= 1;
            m_cnt  <= 0;
            m_lim  <= (int'(len) > 4096) ? 4096 : int'(len);
          end
        end
      end else if (bus.in_valid) begin
        m_we    <= 1;
        m_addr  <= m_cnt % 4096;
        m_wdata <= int'(bus.in_data);
        m_sum   <= (m_sum + int'(bus.in_data)) % 256;
        m_cnt   <= m_cnt + 1;
        if (m_cnt + 1 == m_lim) m_mode <= 2;
      end
    end
  end

  // Write log of what the DUT actually put on the store port.
  int wa[$];
  int wd[$];
  int wc[$];

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit exp_load, exp_done, err;
    exp_load = (m_mode == 1);
    exp_done = (m_mode == 2);
    err = (bus.in_ready !== exp_load) || (busy !== exp_load) ||
          (cpu_hold !== exp_load) || (done !== exp_done) ||
          (bus.mem_we !== m_we) || (checksum !== 8'(m_sum));
    if (m_we || !reset_n)
      err = err || (bus.mem_addr !== 12'(m_addr)) || (bus.mem_wdata !== 8'(m_wdata));
    total++;
    if (err) begin
      bad++;
      $display("FAIL cycle%0d: dut rdy=%b busy=%b hold=%b done=%b we=%b addr=%h wd=%h sum=%h | want rdy=%b done=%b we=%b addr=%h wd=%h sum=%h",
               cyc, bus.in_ready, busy, cpu_hold, done, bus.mem_we, bus.mem_addr,
               bus.mem_wdata, checksum, exp_load, exp_done, m_we, 12'(m_addr),
               8'(m_wdata), 8'(m_sum));
    end
    if (bus.mem_we === 1'b1) begin
      wa.push_back(int'(bus.mem_addr));
      wd.push_back(int'(bus.mem_wdata));
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = 13'(l);
    tick();
    start = 1'b0;
  endtask

  logic [7:0] tx[$];

  // Feed tx through the handshake; toggle inserts an idle cycle between offers.
  task automatic stream(input bit toggle, input int budget);
    int i = 0;
    int n = 0;
    bit ph = 0;
    bit acc;
    while (i < tx.size() && n < budget) begin
      if (toggle && ph) bus.in_valid = 1'b0;
      else begin
        bus.in_valid = 1'b1;
        bus.in_data  = tx[i];
      end
      ph  = !ph;
      acc = bus.in_valid && bus.in_ready;
      tick();
      n++;
      if (acc) i++;
    end
    bus.in_valid = 1'b0;
    if (i < tx.size()) chk("stream_timeout", i, tx.size());
  endtask

  task automatic extra_valid(input int n);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    repeat (n) tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, wa.size(), tx.size());
    for (int k = 0; k < tx.size() && k < wa.size(); k++) begin
      chk({name, "_addr"}, wa[k], k);
      chk({name, "_data"}, wd[k], int'(tx[k]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int expsum;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    reset_n = 1'b1;

    // Idle ignores in_valid
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("idle_writes", wa.size(), 0);

    // Back-to-back load of four bytes
    clr_log();
    tx = '{8'h21, 8'h45, 8'hA1, 8'hE0};
    do_start(4);
    stream(1'b0, 50);
    chk("b2b_done", done, 1);
    chk("b2b_checksum", checksum, 8'hE7);
    chk("b2b_in_ready", bus.in_ready, 0);
    extra_valid(3);
    chk_log("b2b");
    if (wc.size() == 4) chk("b2b_consecutive", wc[3] - wc[0], 3);
    else chk("b2b_wc_size", wc.size(), 4);

    // Same load with in_valid toggling, restarted from DONE
    clr_log();
    do_start(4);
    chk("restart_done_clear", done, 0);
    chk("restart_cpu_hold", cpu_hold, 1);
    chk("restart_checksum_clear", checksum, 0);
    stream(1'b1, 50);
    chk("tog_checksum", checksum, 8'hE7);
    extra_valid(2);
    chk_log("tog");

    // Empty load
    clr_log();
    do_start(0);
    chk("empty_done", done, 1);
    chk("empty_checksum", checksum, 0);
    repeat (3) tick();
    chk("empty_writes", wa.size(), 0);

    // Oversized length clamps to the store depth
    clr_log();
    tx.delete();
    expsum = 0;
    for (int i = 0; i < 4096; i++) begin
      tx.push_back(8'((i * 7 + 3) ^ (i >> 8)));
      expsum = (expsum + int'(tx[i])) % 256;
    end
    do_start(5000);
    stream(1'b0, 5000);
    chk("big_done", done, 1);
    chk("big_checksum", checksum, expsum);
    extra_valid(3);
    chk("big_count", wa.size(), 4096);
    if (wa.size() > 0) begin
      chk("big_first_addr", wa[0], 0);
      chk("big_last_addr", wa[wa.size()-1], 12'hFFF);
    end

    // start pulsed during LOAD is ignored
    clr_log();
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_start(4);
    bus.in_valid = 1'b1; bus.in_data = 8'h11; tick();
    bus.in_data = 8'h22; start = 1'b1; len = 13'd1; tick();
    start = 1'b0;
    bus.in_data = 8'h33; tick();
    bus.in_data = 8'h44; tick();
    bus.in_valid = 1'b0;
    chk("midstart_done", done, 1);
    chk("midstart_checksum", checksum, 8'hAA);
    tick(); tick();
    chk_log("midstart");

    // Reset after two of four beats
    clr_log();
    do_start(4);
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; tick();
    bus.in_data = 8'h6B; tick();
    #2 reset_n = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    chk("mrst_in_ready", bus.in_ready, 0);
    chk("mrst_mem_we", bus.mem_we, 0);
    chk("mrst_mem_addr", bus.mem_addr, 0);
    chk("mrst_mem_wdata", bus.mem_wdata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cpu_hold", cpu_hold, 0);
    chk("mrst_done", done, 0);
    chk("mrst_checksum", checksum, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    chk("mrst_writes", wa.size(), 1);

    // Fresh two-byte load after reset
    clr_log();
    tx = '{8'hC3, 8'h3C};
    do_start(2);
    stream(1'b0, 20);
    chk("len2_checksum", checksum, 8'hFF);
    extra_valid(3);
    chk_log("len2");

    // Second load in sequence from DONE
    clr_log();
    tx = '{8'h01, 8'h02, 8'h03};
    do_start(3);
    chk("seq_done_clear", done, 0);
    chk("seq_checksum_clear", checksum, 0);
    stream(1'b0, 20);
    chk("seq_done", done, 1);
    chk("seq_checksum", checksum, 8'h06);
    tick(); tick();
    chk_log("seq");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
